// File: rtl/ring_counter_multi_pkg.sv
// Shared types and helpers for the multi-mode ring counter.
package ring_counter_multi_pkg;

    // Upper bound on counter width that the helper functions can inspect.
    localparam int RC_MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        RC_MODE_RING    = 2'b00,
        RC_MODE_JOHNSON = 2'b01,
        RC_MODE_BOUNCE  = 2'b10,
        RC_MODE_RSVD    = 2'b11
    } rc_mode_e;

    // HOME is a single one in bit 0, whatever the counter width.
    function automatic logic [RC_MAX_WIDTH-1:0] rc_home();
        return RC_MAX_WIDTH'(1);
    endfunction

    function automatic logic rc_is_onehot(input logic [RC_MAX_WIDTH-1:0] v);
        return ($countones(v) == 1);
    endfunction

    // Number of adjacent-bit transitions within the low `width` bits.
    function automatic int rc_johnson_trans(input logic [RC_MAX_WIDTH-1:0] v,
                                            input int width);
        int n;
        n = 0;
        for (int i = 0; i < RC_MAX_WIDTH - 1; i++) begin
            if ((i < width - 1) && (v[i] != v[i+1])) begin
                n++;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/ring_counter_multi_if.sv
// Control/status bundle between the wrapper and the ring counter.
interface ring_counter_multi_if #(
    parameter int WIDTH     = 4,
    parameter int DIV_WIDTH = 16
);
    logic                 i_enable;
    logic [1:0]           i_mode;
    logic                 i_dir;
    logic                 i_load;
    logic [WIDTH-1:0]     i_load_value;
    logic [DIV_WIDTH-1:0] i_prescale;
    logic [WIDTH-1:0]     o_count_out;
    logic [WIDTH-1:0]     o_io_oeb;
    logic                 o_wrap;
    logic                 o_error;

    modport master (
        output i_enable, i_mode, i_dir, i_load, i_load_value, i_prescale,
        input  o_count_out, o_io_oeb, o_wrap, o_error
    );

    modport slave (
        input  i_enable, i_mode, i_dir, i_load, i_load_value, i_prescale,
        output o_count_out, o_io_oeb, o_wrap, o_error
    );
endinterface

// File: rtl/ring_counter_multi_prescaler.sv
// Tick prescaler: one tick every Prescale+1 enabled cycles.
module rc_prescaler #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_enable,
    input  logic                 i_clear,
    input  logic [DIV_WIDTH-1:0] i_prescale,
    output logic                 o_tick
);
    logic [DIV_WIDTH-1:0] r_pre_cnt;
    logic                 w_tick;

    // >= rather than == so lowering Prescale mid-count ticks immediately.
    assign w_tick = i_enable && (r_pre_cnt >= i_prescale);
    assign o_tick = w_tick;

    // Count enabled cycles, restart on tick, clear or reset.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_pre_cnt <= '0;
        end else if (w_tick) begin
            r_pre_cnt <= '0;
        end else if (i_enable) begin
            r_pre_cnt <= r_pre_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/ring_counter_multi.sv
// Multi-mode ring counter (ring / Johnson / bounce) driving user IO pads.
module ring_counter_multi
    import ring_counter_multi_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int DIV_WIDTH = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    ring_counter_multi_if.slave bus
);
    localparam logic [WIDTH-1:0] L_HOME = WIDTH'(rc_home());

    logic [WIDTH-1:0]        r_count;
    logic                    r_bdir;
    logic                    r_wrap;
    logic                    r_error;
    logic [WIDTH-1:0]        r_oeb;

    logic                    w_tick;
    rc_mode_e                w_mode;
    logic [RC_MAX_WIDTH-1:0] w_ext;
    logic                    w_legal;
    logic                    w_bdir_eff;
    logic [WIDTH-1:0]        w_step;
    logic                    w_step_bdir;

    rc_prescaler #(.DIV_WIDTH(DIV_WIDTH)) u_prescaler (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_enable   (bus.i_enable),
        .i_clear    (bus.i_load),
        .i_prescale (bus.i_prescale),
        .o_tick     (w_tick)
    );

    assign w_mode = rc_mode_e'(bus.i_mode);
    assign w_ext  = RC_MAX_WIDTH'(r_count);

    // Legality of the current state under the currently selected mode.
    always_comb begin
        w_legal = 1'b1;
        case (w_mode)
            RC_MODE_RING, RC_MODE_BOUNCE: w_legal = rc_is_onehot(w_ext);
            RC_MODE_JOHNSON:              w_legal = (rc_johnson_trans(w_ext, WIDTH) <= 1);
            default:                      w_legal = 1'b1;
        endcase
    end

    // Candidate next state for a legal step.
    always_comb begin
        w_step      = r_count;
        w_step_bdir = r_bdir;
        w_bdir_eff  = r_bdir;
        case (w_mode)
            RC_MODE_RING: begin
                w_step = bus.i_dir ? {r_count[0], r_count[WIDTH-1:1]}
                                   : {r_count[WIDTH-2:0], r_count[WIDTH-1]};
            end
            RC_MODE_JOHNSON: begin
                w_step = bus.i_dir ? {~r_count[0], r_count[WIDTH-1:1]}
                                   : {r_count[WIDTH-2:0], ~r_count[WIDTH-1]};
            end
            RC_MODE_BOUNCE: begin
                // A state already sitting at an end (after load or mode switch)
                // reflects instead of shifting out.
                if (!r_bdir && r_count[WIDTH-1]) begin
                    w_bdir_eff = 1'b1;
                end else if (r_bdir && r_count[0]) begin
                    w_bdir_eff = 1'b0;
                end
                w_step = w_bdir_eff ? (r_count >> 1) : (r_count << 1);
                if (w_step[WIDTH-1]) begin
                    w_step_bdir = 1'b1;
                end else if (w_step[0]) begin
                    w_step_bdir = 1'b0;
                end else begin
                    w_step_bdir = w_bdir_eff;
                end
            end
            default: begin
                w_step = r_count;
            end
        endcase
    end

    // Counter, bounce direction, flag pulses and pad enables.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= L_HOME;
            r_bdir  <= 1'b0;
            r_wrap  <= 1'b0;
            r_error <= 1'b0;
            r_oeb   <= '1;
        end else begin
            r_oeb   <= '0;
            r_wrap  <= 1'b0;
            r_error <= 1'b0;
            if (bus.i_load) begin
                r_count <= bus.i_load_value;
                r_bdir  <= 1'b0;
            end else if (w_tick && (w_mode != RC_MODE_RSVD)) begin
                if (!w_legal) begin
                    r_count <= L_HOME;
                    r_bdir  <= 1'b0;
                    r_error <= 1'b1;
                end else begin
                    r_count <= w_step;
                    r_bdir  <= w_step_bdir;
                    r_wrap  <= (w_step == L_HOME);
                end
            end
        end
    end

    assign bus.o_count_out = r_count;
    assign bus.o_io_oeb    = r_oeb;
    assign bus.o_wrap      = r_wrap;
    assign bus.o_error     = r_error;
endmodule

// File: tb/tb_ring_counter_multi.sv
// Scoreboard bench for ring_counter_multi with a position-based reference model.
module tb_ring_counter_multi;
    localparam int W  = 4;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ring_counter_multi_if #(.WIDTH(W), .DIV_WIDTH(DW)) bus ();

    ring_counter_multi #(.WIDTH(W), .DIV_WIDTH(DW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [W-1:0] cnt;
        logic [W-1:0] oeb;
        logic         wrap;
        logic         err;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    // Reference model state
    logic [W-1:0] m_cnt;
    int           m_pre;
    bit           m_bdir;
    logic [W-1:0] jtab[2*W];

    // Current stimulus settings for directed runs
    bit       c_en;
    bit [1:0] c_mode;
    bit       c_dir;
    int       c_ps;

    function automatic int onehot_pos(input logic [W-1:0] v);
        int p;
        p = -1;
        if ($countones(v) == 1)
            for (int i = 0; i < W; i++) if (v[i]) p = i;
        return p;
    endfunction

    function automatic int johnson_idx(input logic [W-1:0] v);
        int k;
        k = -1;
        for (int i = 0; i < 2*W; i++) if (jtab[i] == v) k = i;
        return k;
    endfunction

    task automatic drive(input bit r, input bit en, input bit [1:0] md, input bit d,
                         input bit ld, input logic [W-1:0] lv, input int ps);
        exp_t ex;
        bit   tick;
        bit   legal;
        int   p, k, np;
        bit   dd;
        @(negedge clk);
        rst                = r;
        bus.i_enable       = en;
        bus.i_mode         = md;
        bus.i_dir          = d;
        bus.i_load         = ld;
        bus.i_load_value   = lv;
        bus.i_prescale     = DW'(ps);
        ex.wrap = 1'b0;
        ex.err  = 1'b0;
        if (r) begin
            m_cnt  = W'(1);
            m_pre  = 0;
            m_bdir = 1'b0;
            ex.oeb = '1;
        end else begin
            ex.oeb = '0;
            if (ld) begin
                m_cnt  = lv;
                m_pre  = 0;
                m_bdir = 1'b0;
            end else begin
                tick = en && (m_pre >= ps);
                if (tick) m_pre = 0;
                else if (en) m_pre = m_pre + 1;
                if (tick && md != 2'd3) begin
                    p = onehot_pos(m_cnt);
                    k = johnson_idx(m_cnt);
                    legal = (md == 2'd1) ? (k >= 0) : (p >= 0);
                    if (!legal) begin
                        m_cnt  = W'(1);
                        m_bdir = 1'b0;
                        ex.err = 1'b1;
                    end else begin
                        if (md == 2'd0) begin
                            np    = d ? (p + W - 1) % W : (p + 1) % W;
                            m_cnt = W'(1) << np;
                        end else if (md == 2'd1) begin
                            m_cnt = d ? jtab[(k + 2*W - 1) % (2*W)] : jtab[(k + 1) % (2*W)];
                        end else begin
                            dd = m_bdir;
                            if (!dd && p == W-1) dd = 1'b1;
                            if (dd && p == 0) dd = 1'b0;
                            np     = dd ? p - 1 : p + 1;
                            m_bdir = (np == W-1) ? 1'b1 : (np == 0) ? 1'b0 : dd;
                            m_cnt  = W'(1) << np;
                        end
                        ex.wrap = (m_cnt == W'(1));
                    end
                end
            end
        end
        ex.cnt = m_cnt;
        q.push_back(ex);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, c_en, c_mode, c_dir, 1'b0, '0, c_ps);
    endtask

    task automatic do_load(input logic [W-1:0] lv);
        drive(1'b0, c_en, c_mode, c_dir, 1'b1, lv, c_ps);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, c_en, c_mode, c_dir, 1'b0, '0, c_ps);
    endtask

    // Monitor: one registered result per clock, compared against the scoreboard.
    initial begin
        exp_t ex;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (q.size() > 0) begin
                ex = q.pop_front();
                n_tests++;
                if (bus.o_count_out !== ex.cnt || bus.o_io_oeb !== ex.oeb ||
                    bus.o_wrap !== ex.wrap || bus.o_error !== ex.err) begin
                    n_fail++;
                    $display("FAIL outputs cyc=%0d got cnt=%b oeb=%b wrap=%b err=%b exp cnt=%b oeb=%b wrap=%b err=%b",
                             cyc, bus.o_count_out, bus.o_io_oeb, bus.o_wrap, bus.o_error,
                             ex.cnt, ex.oeb, ex.wrap, ex.err);
                end
            end
        end
    end

    initial begin
        for (int k = 0; k <= W; k++) jtab[k] = W'((1 << k) - 1);
        for (int k = W + 1; k < 2*W; k++) jtab[k] = ~W'((1 << (k - W)) - 1);
        bus.i_enable = 1'b1; bus.i_mode = 2'd0; bus.i_dir = 1'b0;
        bus.i_load = 1'b0; bus.i_load_value = '0; bus.i_prescale = '0;

        // Ring, free-running at full rate
        c_en = 1'b1; c_mode = 2'd0; c_dir = 1'b0; c_ps = 0;
        do_reset(2);
        run(8);

        // Johnson at Prescale=2, then reversed
        c_mode = 2'd1; c_ps = 2;
        do_load(W'(1));
        run(27);
        c_dir = 1'b1;
        run(6);

        // Bounce
        c_mode = 2'd2; c_dir = 1'b0; c_ps = 0;
        do_load(W'(1));
        run(8);

        // Illegal load under ring with coincident tick
        c_mode = 2'd0;
        do_load(4'b0101);
        run(2);

        // Johnson state caught by a switch to ring, then reserved hold
        c_mode = 2'd1;
        do_load(4'b0111);
        c_mode = 2'd0;
        run(1);
        c_mode = 2'd3;
        run(20);

        // Enable low hold, then reset mid-count
        c_mode = 2'd2; c_ps = 3;
        do_load(4'b0100);
        run(1);
        c_en = 1'b0;
        run(10);
        c_en = 1'b1;
        run(1);
        do_reset(1);
        run(5);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) c_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) c_dir  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 49) == 0) c_ps   = $urandom_range(0, 3);
            c_en = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 99) == 0)      do_reset(1);
            else if ($urandom_range(0, 29) == 0) do_load(W'($urandom_range(0, (1 << W) - 1)));
            else                                 run(1);
        end

        @(posedge clk);
        #3;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d exp 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
